// File: rtl/rr_mux_arb.sv
// N-channel valid/ready mux with run-time selectable round-robin or fixed-priority
// arbitration and a single registered output stage (1-cycle latency, full throughput).
module rr_mux_arb #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic                 fixed_pri,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_grant,
    input  logic                 out_ready
);
    localparam int IW = $clog2(N);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    winner;
    logic             found;
    logic             load_en;
    logic [WIDTH-1:0] sel_data;
    int unsigned      idx;

    assign load_en = !out_valid || out_ready;

    // Search starts at ptr in round-robin mode, at 0 in fixed mode; wrap is explicit for non-power-of-2 N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = fixed_pri ? k : k + 32'(ptr);
            if (idx >= N) idx = idx - N;
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (winner == IW'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load_en && found && !rst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_grant <= winner;
                ptr       <= (winner == IW'(N-1)) ? '0 : winner + IW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
